// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: mode/state encodings and per-mode seed shared by the counter controller
package counter_ctrl_pkg;
  typedef enum logic [1:0] {MODE_BIN = 2'd0, MODE_RING = 2'd1, MODE_JOHN = 2'd2, MODE_RSVD = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_e;
  function automatic logic [31:0] seed(input logic [1:0] mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction
endpackage

// File: rtl/cnt_next_value.sv
// cnt_next_value: per-mode next count, terminal detect and ring/johnson legality check
module cnt_next_value
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] nxt,
  output logic             is_tc,
  output logic             illegal
);
  localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] inv;
  logic one_hot, thermo;
  assign inv = ~cnt;
  assign one_hot = (cnt != '0) && ((cnt & (cnt - WIDTH'(1))) == '0);
  // 0*1* means adding one carries through every set bit; 1*0* is the same test on the complement
  assign thermo = ((cnt & (cnt + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
  assign nxt = (mode == MODE_BIN)  ? cnt + WIDTH'(1) :
               (mode == MODE_RING) ? {cnt[WIDTH-2:0], cnt[WIDTH-1]} :
               (mode == MODE_JOHN) ? {cnt[WIDTH-2:0], ~cnt[WIDTH-1]} : cnt;
  assign is_tc = (mode == MODE_BIN) ? &cnt :
                 (mode == MODE_RING || mode == MODE_JOHN) ? (cnt == TOP) : 1'b0;
  assign illegal = (mode == MODE_RING) ? !one_hot :
                   (mode == MODE_JOHN) ? !thermo : 1'b0;
endmodule

// File: rtl/counter_mode_ctrl.sv
// counter_mode_ctrl: IDLE/LOAD/RUN controller for a binary/ring/johnson counter with mode handshake
module counter_mode_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_oneshot,
  input  logic             i_cfg_vld,
  input  logic [1:0]       i_cfg_mode,
  output logic             o_cfg_rdy,
  output logic [1:0]       o_mode,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_busy,
  output logic             o_err
);
  state_e state;
  logic [WIDTH-1:0] nxt, seed_val;
  logic is_tc, illegal;
  cnt_next_value #(.WIDTH(WIDTH)) u_next (
    .mode(o_mode),
    .cnt(o_cnt),
    .nxt(nxt),
    .is_tc(is_tc),
    .illegal(illegal)
  );
  assign seed_val = WIDTH'(seed(o_mode));
  assign o_cfg_rdy = state == IDLE;
  assign o_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o_cnt <= '0;
      o_mode <= 2'd0;
      o_tc <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_tc <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cfg_vld) begin
            if (i_cfg_mode == MODE_RSVD) o_err <= 1'b1;
            else o_mode <= i_cfg_mode;
          end
          if (i_start && !i_stop) state <= LOAD;
        end
        LOAD: begin
          o_cnt <= seed_val;
          state <= i_stop ? IDLE : RUN;
        end
        RUN: begin
          if (i_stop) state <= IDLE;
          else if (illegal) begin
            o_cnt <= seed_val;
            o_err <= 1'b1;
          end else begin
            o_cnt <= nxt;
            if (is_tc) begin
              o_tc <= 1'b1;
              if (i_oneshot) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/counter_mode_ctrl.md
COUNTER_MODE_CTRL -- requirements
Module: counter_mode_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits (>=3).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_start  input  1  start request, sampled in IDLE.
REQ-005 Port: i_stop  input  1  stop request, sampled in LOAD/RUN; also blocks start in IDLE.
REQ-006 Port: i_oneshot  input  1  when 1, stop automatically after first wrap.
REQ-007 Port: i_cfg_vld  input  1  mode-change request; held until accepted.
REQ-008 Port: i_cfg_mode  input  2  requested mode: 0 binary, 1 ring, 2 johnson, 3 reserved.
REQ-009 Port: o_cfg_rdy  output  1  mode change accepted when i_cfg_vld && o_cfg_rdy.
REQ-010 Port: o_mode  output  2  active mode register.
REQ-011 Port: o_cnt  output  WIDTH  counter value, registered.
REQ-012 Port: o_tc  output  1  one-cycle wrap pulse, registered.
REQ-013 Port: o_busy  output  1  high in LOAD and RUN.
REQ-014 Port: o_err  output  1  one-cycle pulse: reserved mode request or illegal ring/johnson state.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN.
- IDLE: o_cnt holds; i_start && !i_stop -> LOAD; otherwise stay.
- LOAD: o_cnt <= seed(o_mode); i_stop -> IDLE (seed still loaded); else -> RUN.
- RUN: o_cnt advances every cycle; i_stop -> IDLE with o_cnt frozen, no advance on that edge; i_start ignored.
REQ-016 Seeds SHALL be: binary 0, ring 0...01, johnson 0...0.
REQ-017 Advance rules SHALL be:
- binary: +1 mod 2^WIDTH; terminal all-ones.
- ring: rotate left; terminal 10...0.
- johnson: shift left, LSB <= ~MSB; terminal 10...0.
REQ-018 On the edge advancing from terminal to seed, o_tc SHALL be 1 for exactly the following cycle, coincident with o_cnt == seed.
REQ-019 If i_oneshot is 1 on the wrap edge, state SHALL go to IDLE on that edge, with o_cnt = seed and o_tc pulsed.
REQ-020 Latency: i_start sampled at edge N -> LOAD after N; seed on o_cnt after N+1; first advance at N+2.
REQ-021 o_cfg_rdy SHALL equal (state == IDLE), combinationally.
- Accepted modes 0-2 update o_mode on the accept edge.
- Accepted mode 3 leaves o_mode unchanged and pulses o_err.
REQ-022 Accept and i_start on the same edge: LOAD SHALL use the newly accepted mode.
REQ-023 In RUN with ring mode and o_cnt not one-hot, or johnson mode and o_cnt not of the form 0*1* or 1*0*, the next edge SHALL load the seed and pulse o_err; o_tc SHALL stay 0.
REQ-024 o_mode SHALL never change outside IDLE.

Reset
REQ-025 While rst_n is 0, the block SHALL immediately set state=IDLE, o_cnt=0, o_mode=0, o_tc=0, o_err=0, o_busy=0, and o_cfg_rdy=1, including mid-RUN.
REQ-026 The first edge after rst_n deasserts SHALL be evaluated as a normal IDLE cycle.

Structure
REQ-027 Mode encodings, state encodings and the seed definition SHALL live in the shared package counter_ctrl_pkg.
REQ-028 Next-value, terminal detect and legality check SHALL be one combinational sub-module, cnt_next_value (inputs mode and cnt; outputs nxt, is_tc, illegal).
REQ-029 The FSM, mode register, o_cnt register and pulse registers SHALL reside in counter_mode_ctrl.

Verification (WIDTH=4)
REQ-030 Binary: cfg mode 0, start -> o_cnt 0,1,...,15,0; o_tc high only in the cycle o_cnt returns to 0; o_busy 1 throughout.
REQ-031 Ring with i_oneshot=1: start -> 0001,0010,0100,1000,0001; o_tc pulses once; state IDLE, o_busy 0, o_cnt holds 0001.
REQ-032 Johnson: start -> 0000,0001,0011,0111,1111,1110,1100,1000,0000; o_tc pulses at return to 0000; no o_err.
REQ-033 i_cfg_vld=1 with mode 2 during RUN -> o_cfg_rdy 0, o_mode unchanged; i_stop -> o_cnt frozen, accept on the first IDLE cycle, o_mode=2.
REQ-034 In IDLE, i_start and i_stop together -> stay IDLE, o_busy 0. Cfg mode 3 -> o_err one cycle, o_mode unchanged.
REQ-035 rst_n low asynchronously mid-RUN at o_cnt=7 -> o_cnt=0, o_mode=0, o_busy=0 before the next edge. Forced illegal ring state 0110 -> next o_cnt 0001 with o_err pulse.
